// File: rtl/i2c_slave_buf_ctrl_if.sv
// Handshake bundle between the host, the buffer controller and the I2C slave:
// host TX push, host RX pop, slave-side TX pop and slave-side RX push.
interface i2c_slave_buf_ctrl_if;
  // Host pushes bytes destined for the I2C master into the TX FIFO
  logic       host_tx_valid;
  logic [7:0] host_tx_data;
  logic       host_tx_ready;
  // Host pops bytes received from the I2C master out of the RX FIFO
  logic       host_rx_valid;
  logic [7:0] host_rx_data;
  logic       host_rx_ready;
  // I2C slave pulls TX bytes; data appears the cycle after the read strobe
  logic       stxfifo_empty;
  logic [7:0] stx_fifo_dat;
  logic       stx_fifo_rd_en;
  // I2C slave pushes received bytes, throttled by the almost-full hint
  logic       srxfifo_en;
  logic [7:0] rx_sdat;
  logic       rxfifo_almost_full;

  // Seen from the buffer controller
  modport slave (
    input  host_tx_valid, host_tx_data, host_rx_ready,
    input  stx_fifo_rd_en, srxfifo_en, rx_sdat,
    output host_tx_ready, host_rx_valid, host_rx_data,
    output stxfifo_empty, stx_fifo_dat, rxfifo_almost_full
  );

  // Seen from whoever drives the host and I2C-slave sides
  modport master (
    output host_tx_valid, host_tx_data, host_rx_ready,
    output stx_fifo_rd_en, srxfifo_en, rx_sdat,
    input  host_tx_ready, host_rx_valid, host_rx_data,
    input  stxfifo_empty, stx_fifo_dat, rxfifo_almost_full
  );
endinterface

// File: rtl/i2c_slave_buf_ctrl.sv
// Buffer controller for an I2C slave: enable/config sequencing, a TX FIFO the
// slave drains with a registered read port, an RX FIFO the host drains with a
// show-ahead read port, and sticky underflow/overflow status.
module i2c_slave_buf_ctrl #(
  parameter int DEPTH    = 8,
  parameter int AFULL_TH = 6
) (
  input  logic                     wclk,
  input  logic                     rst_wclk_n,
  input  logic                     cfg_en,
  input  logic [7:0]               cfg_addr,
  input  logic [7:0]               cfg_mcode,
  input  logic                     sts_clr,
  output logic                     slave_en,
  output logic [7:0]               slave_addr,
  output logic [7:0]               master_code,
  output logic [$clog2(DEPTH):0]   tx_level,
  output logic [$clog2(DEPTH):0]   rx_level,
  output logic                     tx_underflow,
  output logic                     rx_overflow,
  i2c_slave_buf_ctrl_if.slave      bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_LVL = LW'(AFULL_TH);

  typedef enum logic [1:0] {ST_OFF, ST_CFG, ST_ON, ST_DRAIN} state_e;

  state_e        state_q;
  logic          slave_en_q;
  logic [7:0]    slave_addr_q, master_code_q;

  logic [7:0]    tx_mem [DEPTH];
  logic [PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [LW-1:0] tx_level_q, tx_level_d;
  logic [7:0]    tx_dat_q, tx_dat_d;
  logic          tx_uflow_q;
  logic          tx_flush, tx_push, tx_pop, tx_uflow_set;

  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [LW-1:0] rx_level_q, rx_level_d;
  logic          rx_oflow_q;
  logic          rx_full, rx_push, rx_pop, rx_oflow_set;

  // Enable sequencing: config is latched only in the one-cycle CFG state, and
  // leaving ON passes through DRAIN so the TX FIFO is flushed before OFF.
  always_ff @(posedge wclk or negedge rst_wclk_n) begin
    if (!rst_wclk_n) begin
      state_q       <= ST_OFF;
      slave_en_q    <= 1'b0;
      slave_addr_q  <= '0;
      master_code_q <= '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          slave_en_q <= 1'b0;
          if (cfg_en) state_q <= ST_CFG;
        end
        ST_CFG: begin
          slave_addr_q  <= cfg_addr;
          master_code_q <= cfg_mcode;
          slave_en_q    <= 1'b1;
          state_q       <= ST_ON;
        end
        ST_ON: begin
          if (!cfg_en) begin
            slave_en_q <= 1'b0;
            state_q    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          slave_en_q <= 1'b0;
          state_q    <= ST_OFF;
        end
        default: begin
          slave_en_q <= 1'b0;
          state_q    <= ST_OFF;
        end
      endcase
    end
  end

  // During DRAIN the TX side refuses pushes and ignores pops so the flush wins.
  assign tx_flush          = (state_q == ST_DRAIN);
  assign bus.host_tx_ready = (tx_level_q < FULL_LVL) && !tx_flush;
  assign bus.stxfifo_empty = (tx_level_q == '0);
  assign tx_push           = bus.host_tx_valid && bus.host_tx_ready;
  assign tx_pop            = bus.stx_fifo_rd_en && (tx_level_q != '0) && !tx_flush;
  assign tx_uflow_set      = bus.stx_fifo_rd_en && (tx_level_q == '0);

  // TX next state: pointers, level and the registered read data word.
  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_level_d  = tx_level_q;
    tx_dat_d    = tx_dat_q;
    if (tx_flush) begin
      tx_wr_ptr_d = '0;
      tx_rd_ptr_d = '0;
      tx_level_d  = '0;
    end else begin
      if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + PW'(1);
      if (tx_pop) begin
        tx_rd_ptr_d = tx_rd_ptr_q + PW'(1);
        tx_dat_d    = tx_mem[tx_rd_ptr_q];
      end
      if (tx_push && !tx_pop) tx_level_d = tx_level_q + LW'(1);
      if (tx_pop && !tx_push) tx_level_d = tx_level_q - LW'(1);
    end
  end

  // A byte arriving while the RX FIFO is full only fits if the host pops the
  // oldest byte in the same cycle; otherwise it is dropped and flagged.
  assign rx_full                = (rx_level_q == FULL_LVL);
  assign bus.host_rx_valid      = (rx_level_q != '0);
  assign bus.host_rx_data       = rx_mem[rx_rd_ptr_q];
  assign bus.rxfifo_almost_full = (rx_level_q >= AFULL_LVL);
  assign rx_pop                 = bus.host_rx_valid && bus.host_rx_ready;
  assign rx_push                = bus.srxfifo_en && (!rx_full || rx_pop);
  assign rx_oflow_set           = bus.srxfifo_en && rx_full && !rx_pop;

  // RX next state: pointers and level.
  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_level_d  = rx_level_q;
    if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + PW'(1);
    if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + PW'(1);
    if (rx_push && !rx_pop) rx_level_d = rx_level_q + LW'(1);
    if (rx_pop && !rx_push) rx_level_d = rx_level_q - LW'(1);
  end

  // FIFO storage has no reset; reset empties the FIFOs through the pointers.
  always_ff @(posedge wclk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= bus.host_tx_data;
    if (rx_push) rx_mem[rx_wr_ptr_q] <= bus.rx_sdat;
  end

  // FIFO bookkeeping and sticky flags; a new error outranks a same-cycle clear.
  always_ff @(posedge wclk or negedge rst_wclk_n) begin
    if (!rst_wclk_n) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_level_q  <= '0;
      tx_dat_q    <= '0;
      tx_uflow_q  <= 1'b0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_level_q  <= '0;
      rx_oflow_q  <= 1'b0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_level_q  <= tx_level_d;
      tx_dat_q    <= tx_dat_d;
      tx_uflow_q  <= tx_uflow_set | (tx_uflow_q & ~sts_clr);
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_level_q  <= rx_level_d;
      rx_oflow_q  <= rx_oflow_set | (rx_oflow_q & ~sts_clr);
    end
  end

  assign slave_en         = slave_en_q;
  assign slave_addr       = slave_addr_q;
  assign master_code      = master_code_q;
  assign bus.stx_fifo_dat = tx_dat_q;
  assign tx_level         = tx_level_q;
  assign rx_level         = rx_level_q;
  assign tx_underflow     = tx_uflow_q;
  assign rx_overflow      = rx_oflow_q;
endmodule
